// File: rtl/rxll_fis_rx_pkg.sv
// Shared definitions for the receive link-layer FIFO word format and
// the frame consumer state machine.
package rxll_fis_rx_pkg;

  // Bit positions inside a 36-bit FIFO word
  localparam int RXLL_SOF = 32;
  localparam int RXLL_EOF = 34;
  localparam int RXLL_ERR = 35;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DROP = 2'd2,
    DONE = 2'd3
  } rxll_state_e;

  // Per-frame error flags, ordered as reported on fis_err
  typedef struct packed {
    logic too_long;
    logic no_sof;
    logic crc;
  } fis_err_t;

endpackage

// File: rtl/rxll_fis_rx.sv
// Frame-gated reader for the receive link-layer FIFO. A frame is only
// started once its EOF is resident, then streamed to transport straight
// from the FWFT head. Frames with a bad start or excess length are
// drained and reported.
module rxll_fis_rx
  import rxll_fis_rx_pkg::*;
#(
  parameter int C_MAX_WORDS = 2049,
  parameter int C_LEN_W     = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [35:0]        fifo_do,
  input  logic               fifo_empty,
  input  logic               fifo_eof_rdy,
  output logic               fifo_rd_en,
  output logic [31:0]        ll_data,
  output logic               ll_sof,
  output logic               ll_eof,
  output logic               ll_valid,
  input  logic               ll_ready,
  output logic               fis_done,
  output logic [7:0]         fis_type,
  output logic [C_LEN_W-1:0] fis_len,
  output logic [2:0]         fis_err,
  output logic [15:0]        drop_cnt
);

  localparam logic [C_LEN_W-1:0] LAST_CNT = C_LEN_W'(C_MAX_WORDS - 1);
  localparam logic [C_LEN_W-1:0] CNT_SAT  = '1;
  localparam logic [C_LEN_W-1:0] CNT_ONE  = C_LEN_W'(1);

  rxll_state_e        state, state_nxt;
  logic [C_LEN_W-1:0] cnt, cnt_nxt;
  fis_err_t           err, err_nxt;
  logic [7:0]         hdr, hdr_nxt;
  logic               finish;
  logic               w_sof, w_eof, w_crc, at_max;
  logic               unused_rsvd;

  assign w_sof       = fifo_do[RXLL_SOF];
  assign w_eof       = fifo_do[RXLL_EOF];
  assign w_crc       = fifo_do[RXLL_ERR];
  assign unused_rsvd = fifo_do[33];
  assign at_max      = (cnt == LAST_CNT);

  // Zero-latency stream and pop decode from the FWFT head
  always_comb begin
    ll_valid   = 1'b0;
    fifo_rd_en = 1'b0;
    case (state)
      XFER: begin
        ll_valid   = !fifo_empty;
        fifo_rd_en = !fifo_empty & ll_ready;
      end
      DROP:    fifo_rd_en = !fifo_empty;
      default: ;
    endcase
  end

  // ll_* are gated by ll_valid so nothing leaks out while idle or dropping
  assign ll_data = ll_valid ? fifo_do[31:0] : 32'd0;
  assign ll_sof  = ll_valid & (cnt == '0);
  assign ll_eof  = ll_valid & (w_eof | at_max);

  // Next-state, word counter, error flags and header capture
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err;
    hdr_nxt   = hdr;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        // eof_rdy is only trusted here; DONE absorbs its clearing lag
        if (fifo_eof_rdy && !fifo_empty) begin
          cnt_nxt        = '0;
          err_nxt        = '0;
          err_nxt.no_sof = !w_sof;
          state_nxt      = w_sof ? XFER : DROP;
        end
      end
      XFER: begin
        if (fifo_rd_en) begin
          cnt_nxt = cnt + CNT_ONE;
          if (cnt == '0) hdr_nxt = fifo_do[7:0];
          if (w_eof) begin
            err_nxt.crc = w_crc;
            state_nxt   = DONE;
            finish      = 1'b1;
          end else if (at_max) begin
            // word already left with a forced ll_eof; discard the rest
            err_nxt.too_long = 1'b1;
            state_nxt        = DROP;
          end
        end
      end
      DROP: begin
        if (fifo_rd_en) begin
          if (cnt != CNT_SAT) cnt_nxt = cnt + CNT_ONE;
          if (cnt == '0) hdr_nxt = fifo_do[7:0];
          if (w_eof) begin
            err_nxt.crc = w_crc;
            state_nxt   = DONE;
            finish      = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus per-frame status published with fis_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      err      <= '0;
      hdr      <= '0;
      fis_done <= 1'b0;
      fis_type <= '0;
      fis_len  <= '0;
      fis_err  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      err      <= err_nxt;
      hdr      <= hdr_nxt;
      fis_done <= finish;
      if (finish) begin
        fis_type <= hdr_nxt;
        fis_len  <= cnt_nxt;
        fis_err  <= err_nxt;
        if (err_nxt.no_sof && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rxll_fis_rx.sv
// Bench for rxll_fis_rx: a behavioural FWFT FIFO feeds frames, a monitor
// records transfers and status pulses, and each test compares them with
// frame-level expectations derived from the frame contents.
module tb_rxll_fis_rx;

  localparam int MAXW = 2049;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [35:0] fifo_do;
  logic        fifo_empty, fifo_eof_rdy, fifo_rd_en;
  logic [31:0] ll_data;
  logic        ll_sof, ll_eof, ll_valid;
  logic        ll_ready = 1'b0;
  logic        fis_done;
  logic [7:0]  fis_type;
  logic [11:0] fis_len;
  logic [2:0]  fis_err;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  int rx_idx = 0;

  rxll_fis_rx #(.C_MAX_WORDS(MAXW), .C_LEN_W(12)) dut (
    .clk(clk), .rst(rst),
    .fifo_do(fifo_do), .fifo_empty(fifo_empty), .fifo_eof_rdy(fifo_eof_rdy),
    .fifo_rd_en(fifo_rd_en),
    .ll_data(ll_data), .ll_sof(ll_sof), .ll_eof(ll_eof), .ll_valid(ll_valid),
    .ll_ready(ll_ready),
    .fis_done(fis_done), .fis_type(fis_type), .fis_len(fis_len),
    .fis_err(fis_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural FWFT FIFO: writer is the stimulus thread, reader is the DUT.
  // eof_rdy is registered so it clears one cycle after the last EOF pops.
  logic [35:0] mem [0:16383];
  int   wr_ptr = 0, rd_ptr = 0, eof_wr = 0, eof_rd = 0;
  logic eof_rdy_q;

  assign fifo_empty   = (rd_ptr == wr_ptr);
  assign fifo_do      = mem[rd_ptr[13:0]];
  assign fifo_eof_rdy = eof_rdy_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= wr_ptr;
      eof_rd    <= eof_wr;
      eof_rdy_q <= 1'b0;
    end else begin
      eof_rdy_q <= (eof_wr - eof_rd) > 0;
      if (fifo_rd_en && !fifo_empty) begin
        rd_ptr <= rd_ptr + 1;
        if (fifo_do[34]) eof_rd <= eof_rd + 1;
      end
    end
  end

  // Monitor: transfers, status pulses and stall-stability
  typedef struct packed { logic [31:0] d; logic s; logic e; logic [31:0] cyc; } beat_t;
  typedef struct packed { logic [7:0] t; logic [11:0] l; logic [2:0] e; logic [31:0] cyc; } done_t;
  beat_t rxq[$];
  done_t dq[$];
  int    cyc = 0;
  int    stall_viol = 0;
  logic  prev_stall = 1'b0;
  logic [33:0] prev_beat = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ll_valid && ll_ready) rxq.push_back('{ll_data, ll_sof, ll_eof, 32'(cyc)});
    if (fis_done) dq.push_back('{fis_type, fis_len, fis_err, 32'(cyc)});
    if (prev_stall && (!ll_valid || {ll_data, ll_sof, ll_eof} != prev_beat))
      stall_viol <= stall_viol + 1;
    prev_stall <= ll_valid && !ll_ready && !rst;
    prev_beat  <= {ll_data, ll_sof, ll_eof};
  end

  task automatic make_frame(input int n, input bit sof, input bit crc, input logic [7:0] typ,
                            output logic [35:0] f[$]);
    logic [35:0] w;
    f = {};
    for (int i = 0; i < n; i++) begin
      w[31:0] = $urandom;
      if (i == 0) w[7:0] = typ;
      w[32] = (i == 0) ? sof : 1'($urandom_range(0, 1));
      w[33] = 1'($urandom_range(0, 1));
      w[34] = (i == n - 1);
      w[35] = (i == n - 1) ? crc : 1'($urandom_range(0, 1));
      f.push_back(w);
    end
  endtask

  task automatic push_words(input logic [35:0] f[$], input int from, input int to);
    for (int i = from; i < to; i++) begin
      mem[wr_ptr[13:0]] = f[i];
      if (f[i][34]) eof_wr++;
      wr_ptr++;
    end
  endtask

  // mode 0: ready high, 1: toggling 1,0,1,0, 2: random
  task automatic drive_until(input int ndone, input int mode, input string name);
    int n = 0;
    ll_ready = 1'b1;
    while (dq.size() < ndone && n < 20000) begin
      @(posedge clk); #1;
      case (mode)
        0:       ll_ready = 1'b1;
        1:       ll_ready = ~ll_ready;
        default: ll_ready = 1'($urandom_range(0, 1));
      endcase
      n++;
    end
    checks++;
    if (dq.size() < ndone) begin
      errors++;
      $display("FAIL %s timeout: fis_done count %0d, required %0d", name, dq.size(), ndone);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Frame-level expectation: what transport must see and what status is reported
  task automatic check_frame(input string name, input logic [35:0] f[$], input int di);
    int n, nem;
    bit good;
    logic [11:0] elen;
    logic [2:0]  eerr;
    logic [33:0] exp_b;
    n    = f.size();
    good = f[0][32];
    nem  = !good ? 0 : ((n > MAXW) ? MAXW : n);
    elen = (n > 4095) ? 12'hFFF : 12'(n);
    eerr = {good && (n > MAXW), !good, f[n-1][35]};
    for (int i = 0; i < nem; i++) begin
      exp_b = {f[i][31:0], 1'(i == 0), 1'(i == nem - 1)};
      checks++;
      if (rx_idx + i >= rxq.size()) begin
        errors++;
        $display("FAIL %s beat %0d missing", name, i);
        break;
      end else if ({rxq[rx_idx+i].d, rxq[rx_idx+i].s, rxq[rx_idx+i].e} !== exp_b) begin
        errors++;
        $display("FAIL %s beat %0d: got %h/%b/%b, required %h/%b/%b", name, i,
                 rxq[rx_idx+i].d, rxq[rx_idx+i].s, rxq[rx_idx+i].e,
                 exp_b[33:2], exp_b[1], exp_b[0]);
      end
    end
    rx_idx += nem;
    checks++;
    if (di >= dq.size()) begin
      errors++;
      $display("FAIL %s no fis_done", name);
    end else begin
      if (dq[di].l !== elen) begin
        errors++;
        $display("FAIL %s fis_len: got %0d, required %0d", name, dq[di].l, elen);
      end
      checks++;
      if (dq[di].e !== eerr) begin
        errors++;
        $display("FAIL %s fis_err: got %b, required %b", name, dq[di].e, eerr);
      end
      if (good) begin
        checks++;
        if (dq[di].t !== f[0][7:0]) begin
          errors++;
          $display("FAIL %s fis_type: got %h, required %h", name, dq[di].t, f[0][7:0]);
        end
      end
    end
    if (!good && exp_drop < 65535) exp_drop++;
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (rxq.size() != rx_idx) begin
      errors++;
      $display("FAIL %s transfer count: got %0d, required %0d", name, rxq.size(), rx_idx);
    end
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL %s drop_cnt: got %0d, required %0d", name, drop_cnt, exp_drop);
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL %s stalled head changed %0d times, required 0", name, stall_viol);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [75:0] outs;
    outs = {fifo_rd_en, ll_valid, ll_sof, ll_eof, ll_data, fis_done, fis_type,
            fis_len, fis_err, drop_cnt};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL %s outputs under reset: got %h, required 0", name, outs);
    end
  endtask

  task automatic test_reset();
    #2;
    check_all_zero("reset");
    settle(2);
    rst = 1'b0;
    settle(2);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_basic();
    logic [35:0] f[$];
    int d0 = dq.size();
    make_frame(5, 1'b1, 1'b0, 8'h34, f);
    push_words(f, 0, 5);
    drive_until(d0 + 1, 0, "basic");
    check_frame("basic", f, d0);
    checks++;
    if (dq.size() > d0 && rxq.size() > 0 && dq[d0].cyc !== rxq[rxq.size()-1].cyc + 1) begin
      errors++;
      $display("FAIL basic done latency: done cycle %0d, eof cycle %0d, required +1",
               dq[d0].cyc, rxq[rxq.size()-1].cyc);
    end
    settle(3);
    checks++;
    if (fis_len !== 12'd5 || fis_type !== 8'h34 || fis_err !== 3'b000) begin
      errors++;
      $display("FAIL basic status hold: got len %0d type %h err %b, required 5 34 000",
               fis_len, fis_type, fis_err);
    end
    check_quiet("basic");
  endtask

  task automatic test_ready_toggle();
    logic [35:0] f[$];
    int d0 = dq.size();
    make_frame(5, 1'b1, 1'b0, 8'h34, f);
    push_words(f, 0, 5);
    drive_until(d0 + 1, 1, "toggle");
    check_frame("toggle", f, d0);
    settle(3);
    check_quiet("toggle");
  endtask

  task automatic test_no_sof();
    logic [35:0] f[$], g[$];
    int d0 = dq.size();
    make_frame(4, 1'b0, 1'b1, 8'h27, f);
    make_frame(3, 1'b1, 1'b0, 8'h46, g);
    push_words(f, 0, 4);
    drive_until(d0 + 1, 0, "no_sof");
    check_frame("no_sof", f, d0);
    settle(3);
    check_quiet("no_sof");
    push_words(g, 0, 3);
    drive_until(d0 + 2, 0, "after_drop");
    check_frame("after_drop", g, d0 + 1);
    settle(3);
    check_quiet("after_drop");
  endtask

  task automatic test_long(input int n, input string name);
    logic [35:0] f[$];
    int d0 = dq.size();
    make_frame(n, 1'b1, 1'b0, 8'h46, f);
    push_words(f, 0, n);
    drive_until(d0 + 1, 0, name);
    check_frame(name, f, d0);
    settle(3);
    check_quiet(name);
  endtask

  task automatic test_back_to_back();
    logic [35:0] a[$], b[$];
    int d0 = dq.size();
    make_frame(1, 1'b1, 1'b0, 8'h39, a);
    make_frame(1, 1'b1, 1'b1, 8'h41, b);
    push_words(a, 0, 1);
    push_words(b, 0, 1);
    drive_until(d0 + 2, 0, "b2b");
    check_frame("b2b_a", a, d0);
    check_frame("b2b_b", b, d0 + 1);
    settle(3);
    check_quiet("b2b");
    // second frame only partly resident: must not start on a stale eof_rdy
    d0 = dq.size();
    make_frame(1, 1'b1, 1'b0, 8'h5f, a);
    make_frame(4, 1'b1, 1'b0, 8'h34, b);
    push_words(a, 0, 1);
    push_words(b, 0, 1);
    drive_until(d0 + 1, 0, "stale_a");
    check_frame("stale_a", a, d0);
    settle(6);
    check_quiet("stale_hold");
    push_words(b, 1, 4);
    drive_until(d0 + 2, 0, "stale_b");
    check_frame("stale_b", b, d0 + 1);
    settle(3);
    check_quiet("stale_b");
  endtask

  task automatic test_random();
    logic [35:0] f[$];
    int d0;
    for (int k = 0; k < 20; k++) begin
      d0 = dq.size();
      make_frame($urandom_range(1, 12), ($urandom_range(0, 6) != 0), 1'($urandom_range(0, 1)),
                 8'($urandom), f);
      push_words(f, 0, f.size());
      drive_until(d0 + 1, 2, "random");
      check_frame("random", f, d0);
      settle(2);
    end
    check_quiet("random");
  endtask

  task automatic test_reset_mid();
    logic [35:0] f[$];
    int d0 = dq.size();
    make_frame(10, 1'b1, 1'b0, 8'h34, f);
    push_words(f, 0, 10);
    ll_ready = 1'b1;
    settle(5);
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid");
    exp_drop = 0;
    rx_idx   = rxq.size();
    settle(2);
    rst = 1'b0;
    settle(4);
    checks++;
    if (dq.size() != d0) begin
      errors++;
      $display("FAIL reset_mid fis_done count: got %0d, required %0d", dq.size(), d0);
    end
    check_quiet("reset_mid");
    make_frame(6, 1'b1, 1'b1, 8'h58, f);
    push_words(f, 0, 6);
    drive_until(d0 + 1, 0, "after_reset");
    check_frame("after_reset", f, d0);
    settle(3);
    check_quiet("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_no_sof();
    test_long(MAXW + 2, "too_long");
    test_long(MAXW, "exact_max");
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
